mem_port_arbiter: RTL and testbench

- Shares one single-ported backing memory between three requesters: instruction fetch read (IF), pipeline memory-read stage (MR) and pipeline memory-writeback stage (MW).
- Sits between the pipeline stage logic and the memory model.
- Returns per-requester finished pulses that drive the existing mr_stall/mw_stall generation.
- Fixed priority MW > MR > IF, so older instructions drain first.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/arb_prio_sel.sv | 29 ++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states, grant IDs
// and the data word returned when an access times out.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_IF = 2'd0,
        GNT_MR = 2'd1,
        GNT_MW = 2'd2
    } gnt_id_e;

    localparam int          NUM_REQ      = 3;
    localparam logic [31:0] ARB_ERR_DATA = 32'hDEADBEEF;

    // Grant vectors are one-hot by construction; MW is checked first to match priority.
    function automatic gnt_id_e onehot_to_id(input logic [NUM_REQ-1:0] gnt);
        if (gnt[GNT_MW]) begin
            return GNT_MW;
        end else if (gnt[GNT_MR]) begin
            return GNT_MR;
        end
        return GNT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and backing-memory signals of the memory port arbiter.
// slave: the arbiter's view; master: the pipeline stages and memory model.
interface mem_port_arbiter_if;
    logic        if_re;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_finished;

    logic        mr_re;
    logic [31:0] mr_addr;
    logic [31:0] mr_data;
    logic        mr_finished;

    logic        mw_we;
    logic [31:0] mw_addr;
    logic [31:0] mw_wdata;
    logic        mw_finished;

    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        err;

    modport slave (
        input  if_re, if_addr, mr_re, mr_addr, mw_we, mw_addr, mw_wdata,
        input  mem_rdata, mem_ack,
        output if_data, if_finished, mr_data, mr_finished, mw_finished,
        output mem_re, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output if_re, if_addr, mr_re, mr_addr, mw_we, mw_addr, mw_wdata,
        output mem_rdata, mem_ack,
        input  if_data, if_finished, mr_data, mr_finished, mw_finished,
        input  mem_re, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/arb_prio_sel.sv
// Combinational grant selection: MW > MR > IF, unless starve_promote lets a
// waiting IF request jump the queue.
module arb_prio_sel
    import mem_arb_pkg::*;
(
    input  logic               if_req,
    input  logic               mr_req,
    input  logic               mw_req,
    input  logic               starve_promote,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any_req
);

    always_comb begin
        gnt = '0;
        if (if_req && starve_promote) begin
            gnt[GNT_IF] = 1'b1;
        end else if (mw_req) begin
            gnt[GNT_MW] = 1'b1;
        end else if (mr_req) begin
            gnt[GNT_MR] = 1'b1;
        end else if (if_req) begin
            gnt[GNT_IF] = 1'b1;
        end
    end

    assign any_req = if_req | mr_req | mw_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF, MR and MW with an IDLE/BUSY/DONE FSM.
// Optional IF anti-starvation promotion is built when MEM_ARB_ANTI_STARVE_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC  = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              r,
    mem_port_arbiter_if.slave bus
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYC);

    arb_state_e         state_reg;
    gnt_id_e            gnt_id_reg;
    gnt_id_e            sel_id;
    logic [31:0]        addr_reg;
    logic [31:0]        wdata_reg;
    logic [31:0]        if_data_reg;
    logic [31:0]        mr_data_reg;
    logic [7:0]         cyc_cnt_reg;
    logic [7:0]         cyc_cnt_next;
    logic [NUM_REQ-1:0] fin_reg;
    logic [NUM_REQ-1:0] sel_gnt;
    logic               mem_re_reg;
    logic               mem_we_reg;
    logic               err_reg;
    logic               any_req;
    logic               starve_promote;
    logic               access_end;
    logic [31:0]        rdata_next;

    arb_prio_sel u_prio_sel (
        .if_req         (bus.if_re),
        .mr_req         (bus.mr_re),
        .mw_req         (bus.mw_we),
        .starve_promote (starve_promote),
        .gnt            (sel_gnt),
        .any_req        (any_req)
    );

    assign sel_id       = onehot_to_id(sel_gnt);
    assign cyc_cnt_next = (cyc_cnt_reg == 8'hFF) ? cyc_cnt_reg : cyc_cnt_reg + 8'd1;
    assign access_end   = bus.mem_ack || (cyc_cnt_next >= TIMEOUT_CNT);
    // A timed-out read returns a recognisable poison word instead of stale data.
    assign rdata_next   = bus.mem_ack ? bus.mem_rdata : ARB_ERR_DATA;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_reg   <= IDLE;
            gnt_id_reg  <= GNT_IF;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            if_data_reg <= '0;
            mr_data_reg <= '0;
            cyc_cnt_reg <= '0;
            fin_reg     <= '0;
            mem_re_reg  <= 1'b0;
            mem_we_reg  <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            fin_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        gnt_id_reg  <= sel_id;
                        addr_reg    <= (sel_id == GNT_MW) ? bus.mw_addr :
                                       (sel_id == GNT_MR) ? bus.mr_addr : bus.if_addr;
                        wdata_reg   <= (sel_id == GNT_MW) ? bus.mw_wdata : 32'h0;
                        cyc_cnt_reg <= '0;
                        mem_we_reg  <= (sel_id == GNT_MW);
                        mem_re_reg  <= (sel_id != GNT_MW);
                        state_reg   <= BUSY;
                    end
                end
                BUSY: begin
                    cyc_cnt_reg <= cyc_cnt_next;
                    if (access_end) begin
                        mem_re_reg          <= 1'b0;
                        mem_we_reg          <= 1'b0;
                        fin_reg[gnt_id_reg] <= 1'b1;
                        state_reg           <= DONE;
                        if (!bus.mem_ack) begin
                            err_reg <= 1'b1;
                        end
                        if (gnt_id_reg == GNT_IF) begin
                            if_data_reg <= rdata_next;
                        end
                        if (gnt_id_reg == GNT_MR) begin
                            mr_data_reg <= rdata_next;
                        end
                    end
                end
                // No arbitration here, so a request still held during DONE is not re-granted.
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_ANTI_STARVE_EN
    logic [2:0] starve_cnt_reg;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            starve_cnt_reg <= '0;
        end else if (state_reg == IDLE && any_req) begin
            if (sel_id == GNT_IF) begin
                starve_cnt_reg <= '0;
            end else if (bus.if_re && starve_cnt_reg != 3'd7) begin
                starve_cnt_reg <= starve_cnt_reg + 3'd1;
            end
        end
    end

    assign starve_promote = (32'(starve_cnt_reg) >= STARVE_LIMIT);
`else
    // Pure fixed priority: IF is never promoted and STARVE_LIMIT has no effect.
    assign starve_promote = 1'b0 && (STARVE_LIMIT != 0);
`endif

    assign bus.if_data     = if_data_reg;
    assign bus.mr_data     = mr_data_reg;
    assign bus.if_finished = fin_reg[GNT_IF];
    assign bus.mr_finished = fin_reg[GNT_MR];
    assign bus.mw_finished = fin_reg[GNT_MW];
    assign bus.mem_re      = mem_re_reg;
    assign bus.mem_we      = mem_we_reg;
    assign bus.mem_addr    = addr_reg;
    assign bus.mem_wdata   = wdata_reg;
    assign bus.err         = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// request batches checked against a priority/memory reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic r   = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT_CYC(64), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    // Memory environment: acks after ack_lat strobed cycles (1 = same cycle).
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    int          ack_lat      = 1;
    bit          ack_stuck    = 1'b0;
    bit          spurious_ack = 1'b0;
    int          busy_cycles  = 0;
    bit          txn_we_q   [$];
    logic [31:0] txn_addr_q [$];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(negedge clk) begin
        if (bus.mem_re === 1'b1 || bus.mem_we === 1'b1) begin
            busy_cycles++;
            if (!ack_stuck && busy_cycles >= ack_lat) begin
                bus.mem_ack = 1'b1;
                if (bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
                bus.mem_rdata = mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr] : init_val(bus.mem_addr);
                txn_we_q.push_back(bus.mem_we);
                txn_addr_q.push_back(bus.mem_addr);
            end else begin
                bus.mem_ack = 1'b0;
            end
        end else begin
            busy_cycles   = 0;
            bus.mem_ack   = spurious_ack;
            bus.mem_rdata = $urandom;
        end
    end

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Reference arbitration: oldest stage first, IF promoted after enough consecutive losses.
    function automatic int model_pick(input bit p_if, input bit p_mr, input bit p_mw, input int losses);
`ifdef MEM_ARB_ANTI_STARVE_EN
        if (p_if && losses >= 4) return 0;
`else
        if (losses < 0) return 0;
`endif
        if (p_mw) return 2;
        if (p_mr) return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        bus.if_re = 0; bus.if_addr = 0; bus.mr_re = 0; bus.mr_addr = 0;
        bus.mw_we = 0; bus.mw_addr = 0; bus.mw_wdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        ack_stuck = 0; spurious_ack = 0; ack_lat = 1;
        @(negedge clk); #2 r = 1'b0;
        repeat (2) @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        txn_we_q.delete(); txn_addr_q.delete();
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 r = 1'b0;
        #1;
        checks++; if ({bus.mem_re, bus.mem_we, bus.err} !== 3'b000) $display("FAIL reset_strobes got=%b want=000", {bus.mem_re, bus.mem_we, bus.err}); else passes++;
        checks++; if ({bus.if_finished, bus.mr_finished, bus.mw_finished} !== 3'b000) $display("FAIL reset_finished got=%b want=000", {bus.if_finished, bus.mr_finished, bus.mw_finished}); else passes++;
        checks++; if (bus.if_data !== 32'h0 || bus.mr_data !== 32'h0) $display("FAIL reset_data got if=%h mr=%h want 0", bus.if_data, bus.mr_data); else passes++;
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0", bus.mem_addr, bus.mem_wdata); else passes++;
        repeat (2) @(negedge clk);
        r = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int seen;
        int fins;
        seen = 0; fins = 0;
        ack_stuck = 1;
        bus.mr_addr = 32'h40; bus.mr_re = 1;
        for (int i = 0; i < 5 && seen == 0; i++) begin
            @(negedge clk);
            if (bus.mem_re === 1'b1) seen = 1;
        end
        checks++; if (seen != 1) $display("FAIL mid_reset_grant got mem_re never high want high within 5 cycles"); else passes++;
        #2 r = 1'b0;
        #1;
        checks++; if (bus.mem_re !== 1'b0) $display("FAIL mid_reset_mem_re got=%b want=0", bus.mem_re); else passes++;
        checks++; if (dut.state_reg !== IDLE) $display("FAIL mid_reset_state got=%0d want=%0d", dut.state_reg, IDLE); else passes++;
        bus.mr_re = 0; ack_stuck = 0;
        @(negedge clk); r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.mr_finished === 1'b1) fins++;
        end
        checks++; if (fins != 0 || bus.err !== 1'b0) $display("FAIL mid_reset_no_finish got fins=%0d err=%b want 0/0", fins, bus.err); else passes++;
        txn_we_q.delete(); txn_addr_q.delete();
    endtask

    task automatic test_spurious_ack();
        int events;
        events = 0;
        spurious_ack = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.if_finished || bus.mr_finished || bus.mw_finished || bus.mem_re || bus.mem_we) events++;
        end
        spurious_ack = 0;
        @(negedge clk);
        checks++; if (events != 0 || bus.err !== 1'b0) $display("FAIL idle_ack_ignored got events=%0d err=%b want 0/0", events, bus.err); else passes++;
    endtask

    task automatic test_single_read();
        int lat;
        bit got;
        lat = 1; got = 0;
        mem_store[32'h100] = 32'hABCD;
        ack_lat = 2;
        txn_we_q.delete();
        bus.mr_addr = 32'h100; bus.mr_re = 1;
        while (lat < 20 && !got) begin
            @(negedge clk); lat++;
            if (bus.mr_finished === 1'b1) got = 1;
        end
        bus.mr_re = 0;
        checks++; if (lat != 4) $display("FAIL single_read_latency got=%0d want=4", lat); else passes++;
        checks++; if (bus.mr_data !== 32'hABCD) $display("FAIL single_read_data got=%h want=0000abcd", bus.mr_data); else passes++;
        checks++; if ({bus.if_finished, bus.mw_finished} !== 2'b00) $display("FAIL single_read_others got=%b want=00", {bus.if_finished, bus.mw_finished}); else passes++;
        @(negedge clk);
        checks++; if (bus.mr_finished !== 1'b0) $display("FAIL single_read_pulse_width got=%b want=0", bus.mr_finished); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (bus.mr_data !== 32'hABCD || txn_we_q.size() != 1) $display("FAIL single_read_retention got data=%h txns=%0d want 0000abcd/1", bus.mr_data, txn_we_q.size()); else passes++;
        $display("txn single_read addr=100 data=%h latency=%0d", bus.mr_data, lat);
        ack_lat = 1;
    endtask

    task automatic test_conflict();
        int cyc;
        int mw_at;
        int mr_at;
        cyc = 0; mw_at = -1; mr_at = -1;
        mem_store[32'h200] = 32'h1111;
        txn_we_q.delete(); txn_addr_q.delete();
        bus.mw_addr = 32'h200; bus.mw_wdata = 32'h55; bus.mw_we = 1;
        bus.mr_addr = 32'h200; bus.mr_re = 1;
        while (cyc < 30 && (mw_at < 0 || mr_at < 0)) begin
            @(negedge clk); cyc++;
            if (bus.mw_finished === 1'b1) begin mw_at = cyc; bus.mw_we = 0; end
            if (bus.mr_finished === 1'b1) begin mr_at = cyc; bus.mr_re = 0; end
        end
        repeat (2) @(negedge clk);
        checks++; if (!(mw_at > 0 && mr_at > mw_at)) $display("FAIL conflict_order got mw_at=%0d mr_at=%0d want mw first", mw_at, mr_at); else passes++;
        checks++; if (txn_we_q.size() != 2 || txn_we_q[0] != 1'b1 || txn_we_q[1] != 1'b0) $display("FAIL conflict_mem_txns got n=%0d want write then read", txn_we_q.size()); else passes++;
        checks++; if (bus.mr_data !== 32'h55) $display("FAIL conflict_raw_data got=%h want=00000055", bus.mr_data); else passes++;
        $display("txn conflict addr=200 write=55 read=%h", bus.mr_data);
    endtask

    task automatic test_held_request();
        int fins;
        bit got;
        fins = 0; got = 0;
        txn_we_q.delete();
        bus.mr_addr = 32'h300; bus.mr_re = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.mr_finished === 1'b1) begin got = 1; fins++; end
        end
        @(posedge clk); #1 bus.mr_re = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.mr_finished === 1'b1) fins++;
        end
        checks++; if (txn_we_q.size() != 1 || fins != 1) $display("FAIL held_request_once got txns=%0d fins=%0d want 1/1", txn_we_q.size(), fins); else passes++;
    endtask

    task automatic test_random();
        logic [31:0] a_if, a_mr, a_mw, wd;
        bit p_if, p_mr, p_mw;
        int losses;
        int exp;
        int budget;
        logic [2:0] fin, want;
        do_reset();
        losses = 0;
        for (int b = 0; b < 20; b++) begin
            ack_lat = $urandom_range(1, 4);
            a_if = 32'h400 + 32'($urandom_range(0, 3)) * 4;
            a_mr = 32'h400 + 32'($urandom_range(0, 3)) * 4;
            a_mw = 32'h400 + 32'($urandom_range(0, 3)) * 4;
            wd = $urandom;
            {p_mw, p_mr, p_if} = 3'($urandom_range(1, 7));
            bus.if_addr = a_if; bus.mr_addr = a_mr; bus.mw_addr = a_mw; bus.mw_wdata = wd;
            bus.if_re = p_if; bus.mr_re = p_mr; bus.mw_we = p_mw;
            budget = 0;
            while ((p_if || p_mr || p_mw) && budget < 300) begin
                @(negedge clk); budget++;
                fin = {bus.mw_finished, bus.mr_finished, bus.if_finished};
                if (fin != 3'b000) begin
                    exp  = model_pick(p_if, p_mr, p_mw, losses);
                    want = 3'b001 << exp;
                    checks++; if (fin !== want) $display("FAIL rand_grant batch=%0d got=%b want=%b", b, fin, want); else passes++;
                    if (exp == 2) ref_mem[a_mw] = wd;
                    if (exp == 1) begin
                        checks++; if (bus.mr_data !== ref_read(a_mr)) $display("FAIL rand_mr_data batch=%0d got=%h want=%h", b, bus.mr_data, ref_read(a_mr)); else passes++;
                    end
                    if (exp == 0) begin
                        checks++; if (bus.if_data !== ref_read(a_if)) $display("FAIL rand_if_data batch=%0d got=%h want=%h", b, bus.if_data, ref_read(a_if)); else passes++;
                    end
                    if (exp == 0) losses = 0;
                    else if (p_if && losses < 7) losses++;
                    $display("txn rand batch=%0d grant=%0d lat=%0d", b, exp, ack_lat);
                    if (exp == 0 || fin[0]) begin p_if = 0; bus.if_re = 0; end
                    if (exp == 1 || fin[1]) begin p_mr = 0; bus.mr_re = 0; end
                    if (exp == 2 || fin[2]) begin p_mw = 0; bus.mw_we = 0; end
                end
            end
            if (budget >= 300) begin
                checks++; $display("FAIL rand_batch_timeout batch=%0d got pending=%b want none", b, {p_mw, p_mr, p_if});
                clear_inputs(); p_if = 0; p_mr = 0; p_mw = 0;
            end
        end
        checks++; if (bus.err !== 1'b0) $display("FAIL rand_err got=%b want=0", bus.err); else passes++;
    endtask

    task automatic test_starvation();
        int arb;
        int if_at;
        int budget;
        bit got;
        do_reset();
        arb = 0; if_at = 0; budget = 0; got = 0;
        bus.if_addr = 32'h500; bus.mw_addr = 32'h504; bus.mw_wdata = $urandom; bus.mr_addr = 32'h508;
        bus.if_re = 1; bus.mw_we = 1;
        while (arb < 6 && if_at == 0 && budget < 100) begin
            @(negedge clk); budget++;
            if (bus.if_finished === 1'b1) begin
                arb++; if_at = arb; clear_inputs();
            end else if (bus.mw_finished === 1'b1) begin
                arb++; bus.mw_we = 0; bus.mr_re = 1;
            end else if (bus.mr_finished === 1'b1) begin
                arb++; bus.mr_re = 0; bus.mw_we = 1;
            end
        end
        bus.mw_we = 0; bus.mr_re = 0;
`ifdef MEM_ARB_ANTI_STARVE_EN
        checks++; if (if_at != 5) $display("FAIL starve_promote got if_arb=%0d want=5", if_at); else passes++;
`else
        checks++; if (if_at != 0 || arb != 6) $display("FAIL starve_fixed_prio got if_arb=%0d arbs=%0d want 0/6", if_at, arb); else passes++;
`endif
        if (bus.if_re) begin
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (bus.if_finished === 1'b1) got = 1;
            end
            checks++; if (!got) $display("FAIL starve_if_drain got no if_finished want one"); else passes++;
            bus.if_re = 0;
        end
        $display("txn starvation if_granted_at=%0d arbitrations=%0d", if_at, arb);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int busy;
        bit got;
        busy = 0; got = 0;
        ack_stuck = 1;
        bus.if_addr = 32'h600; bus.if_re = 1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.mem_re === 1'b1) busy++;
            if (bus.if_finished === 1'b1) got = 1;
        end
        bus.if_re = 0; ack_stuck = 0;
        checks++; if (!got || busy != 64) $display("FAIL timeout_cycles got finished=%0d busy=%0d want 1/64", got, busy); else passes++;
        checks++; if (bus.if_data !== 32'hDEADBEEF) $display("FAIL timeout_data got=%h want=deadbeef", bus.if_data); else passes++;
        checks++; if (bus.err !== 1'b1) $display("FAIL timeout_err got=%b want=1", bus.err); else passes++;
        got = 0;
        bus.mr_addr = 32'h604; bus.mr_re = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.mr_finished === 1'b1) got = 1;
        end
        bus.mr_re = 0;
        @(negedge clk);
        checks++; if (!got || bus.err !== 1'b1) $display("FAIL timeout_err_sticky got finished=%0d err=%b want 1/1", got, bus.err); else passes++;
        $display("txn timeout addr=600 data=%h busy=%0d", bus.if_data, busy);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_reset_mid_access();
        test_spurious_ack();
        test_single_read();
        test_conflict();
        test_held_request();
        test_random();
        test_starvation();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
